// File: rtl/div_fra.sv
// Sequential unsigned fixed-point divider: Q = (A << WIDT_F) / B, restoring, one bit per clock.
// Optional round-to-nearest of the quotient is enabled by defining DIV_FRA_ROUND_EN.
module div_fra #(
   parameter int WIDT_A = 8,
   parameter int WIDT_B = 8,
   parameter int WIDT_F = 8,
   localparam int QW = WIDT_A + WIDT_F
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [WIDT_A-1:0] A,
   input  logic [WIDT_B-1:0] B,
   output logic              BUSY,
   output logic              DONE,
   output logic [QW-1:0]     Q,
   output logic [WIDT_B-1:0] R,
   output logic              DIV0
);

   localparam int CW = (QW > 1) ? $clog2(QW) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t            state, state_nxt;
   logic [WIDT_A-1:0] a_reg;
   logic [WIDT_B-1:0] b_reg;
   logic              b_zero;
   logic [QW-1:0]     dreg;
   logic [QW-1:0]     qreg;
   logic [CW-1:0]     cnt;
   // The partial remainder always stays below B, so its extra top bit is never stored.
   logic [WIDT_B-1:0] preg;
   logic [WIDT_B:0]   trial;
   logic [WIDT_B:0]   diff;
   logic              fits;
   logic [QW-1:0]     q_final;

   assign trial = {preg, dreg[QW-1]};
   assign diff  = trial - {1'b0, b_reg};
   assign fits  = (trial >= {1'b0, b_reg});

`ifdef DIV_FRA_ROUND_EN
   always_comb begin
      q_final = qreg;
      if (({preg, 1'b0} >= {1'b0, b_reg}) && (qreg != {QW{1'b1}}))
         q_final = qreg + QW'(1);
   end
`else
   assign q_final = qreg;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (START) state_nxt = (B == '0) ? FIN : CALC;
         CALC: if (cnt == '0) state_nxt = FIN;
         FIN:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         a_reg  <= '0;
         b_reg  <= '0;
         b_zero <= 1'b0;
         dreg   <= '0;
         qreg   <= '0;
         preg   <= '0;
         cnt    <= '0;
         DONE   <= 1'b0;
         Q      <= '0;
         R      <= '0;
         DIV0   <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  a_reg  <= A;
                  b_reg  <= B;
                  b_zero <= (B == '0);
                  dreg   <= {A, {WIDT_F{1'b0}}};
                  qreg   <= '0;
                  preg   <= '0;
                  cnt    <= CW'(QW - 1);
                  DIV0   <= 1'b0;
               end
            end
            CALC: begin
               dreg <= dreg << 1;
               qreg <= {qreg[QW-2:0], fits};
               preg <= fits ? diff[WIDT_B-1:0] : trial[WIDT_B-1:0];
               if (cnt != '0)
                  cnt <= cnt - 1'b1;
            end
            FIN: begin
               DONE <= 1'b1;
               if (b_zero) begin
                  Q    <= {QW{1'b1}};
                  R    <= WIDT_B'(a_reg);
                  DIV0 <= 1'b1;
               end else begin
                  Q <= q_final;
                  R <= preg;
               end
            end
            default: ;
         endcase
      end
   end

   // DONE is registered on the way out of FIN, so BUSY stretches over that pulse too.
   assign BUSY = (state != IDLE) | DONE;

endmodule

// File: tb/tb_div_fra.sv
// Directed self-checking bench for div_fra with default 8/8/8 parameters.
// Honours DIV_FRA_ROUND_EN when choosing expected quotients.
module tb_div_fra;

   logic        CLK;
   logic        RST;
   logic        START;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        BUSY;
   logic        DONE;
   logic [15:0] Q;
   logic [7:0]  R;
   logic        DIV0;

   int vectors = 0;
   int miscompares = 0;

`ifdef DIV_FRA_ROUND_EN
   localparam logic [15:0] Q_2_3 = 16'h00AB;
`else
   localparam logic [15:0] Q_2_3 = 16'h00AA;
`endif

   div_fra #(.WIDT_A(8), .WIDT_B(8), .WIDT_F(8)) dut (
      .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
      .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R), .DIV0(DIV0)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Launches one operation; returns at the negedge following the accepting edge.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
      @(negedge CLK);
      A = a;
      B = b;
      START = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic doOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input int expLat, input logic [15:0] expQ, input logic [7:0] expR,
                       input logic expDiv0);
      int lat;
      int busyBad;
      applyStimulus(a, b);
      lat = -1;
      busyBad = (BUSY !== 1'b1) ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (BUSY !== 1'b1) busyBad++;
         if (DONE === 1'b1) begin
            lat = k;
            break;
         end
      end
      checkOutput({tag, "_latency"}, lat, expLat);
      checkOutput({tag, "_busy_bad_cycles"}, busyBad, 0);
      checkOutput({tag, "_Q"}, {16'h0, Q}, {16'h0, expQ});
      checkOutput({tag, "_R"}, {24'h0, R}, {24'h0, expR});
      checkOutput({tag, "_DIV0"}, {31'h0, DIV0}, {31'h0, expDiv0});
   endtask

   initial begin
      int doneCount;
      int firstDone;
      int doneAt[3];
      int idleSeen;

      RST = 1'b1;
      START = 1'b0;
      A = '0;
      B = '0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("reset_BUSY", {31'h0, BUSY}, 0);
      checkOutput("reset_DONE", {31'h0, DONE}, 0);
      checkOutput("reset_Q", {16'h0, Q}, 0);
      checkOutput("reset_R", {24'h0, R}, 0);
      checkOutput("reset_DIV0", {31'h0, DIV0}, 0);

      // Basic divide, then confirm the pulse ends and results hold.
      doOp("a3_b2", 8'd3, 8'd2, 17, 16'h0180, 8'd0, 1'b0);
      @(posedge CLK);
      @(negedge CLK);
      checkOutput("a3_b2_after_BUSY", {31'h0, BUSY}, 0);
      checkOutput("a3_b2_after_DONE", {31'h0, DONE}, 0);
      checkOutput("a3_b2_hold_Q", {16'h0, Q}, 32'h0180);

      doOp("a2_b3", 8'd2, 8'd3, 17, Q_2_3, 8'd2, 1'b0);
      doOp("a1_b3", 8'd1, 8'd3, 17, 16'h0055, 8'd1, 1'b0);
      doOp("aFF_b1", 8'hFF, 8'h01, 17, 16'hFF00, 8'd0, 1'b0);
      doOp("aFF_bFF", 8'hFF, 8'hFF, 17, 16'h0100, 8'd0, 1'b0);
      doOp("a5_b0", 8'd5, 8'd0, 1, 16'hFFFF, 8'd5, 1'b1);
      doOp("a4_b2", 8'd4, 8'd2, 17, 16'h0200, 8'd0, 1'b0);

      // START pulses with different operands while busy must be ignored.
      applyStimulus(8'd3, 8'd2);
      doneCount = 0;
      firstDone = -1;
      for (int k = 1; k <= 40; k++) begin
         if (k == 3 || k == 10) begin
            A = 8'd9;
            B = 8'd1;
            START = 1'b1;
         end
         @(posedge CLK);
         @(negedge CLK);
         START = 1'b0;
         if (DONE === 1'b1) begin
            doneCount++;
            if (firstDone < 0) firstDone = k;
         end
      end
      checkOutput("ignore_done_count", doneCount, 1);
      checkOutput("ignore_done_time", firstDone, 17);
      checkOutput("ignore_Q", {16'h0, Q}, 32'h0180);
      checkOutput("ignore_R", {24'h0, R}, 0);

      // START held high re-launches every 18 cycles.
      @(negedge CLK);
      A = 8'd2;
      B = 8'd3;
      START = 1'b1;
      @(posedge CLK);
      doneCount = 0;
      doneAt = '{-1, -1, -1};
      for (int k = 1; k <= 60; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (DONE === 1'b1) begin
            if (doneCount < 3) doneAt[doneCount] = k;
            doneCount++;
         end
      end
      START = 1'b0;
      checkOutput("b2b_done_count", doneCount, 3);
      checkOutput("b2b_first_done", doneAt[0], 17);
      checkOutput("b2b_second_done", doneAt[1], 35);
      checkOutput("b2b_third_done", doneAt[2], 53);
      checkOutput("b2b_Q", {16'h0, Q}, {16'h0, Q_2_3});
      idleSeen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (BUSY === 1'b0 && DONE === 1'b0) begin
            idleSeen = 1;
            break;
         end
      end
      checkOutput("b2b_drain_idle", idleSeen, 1);

      // Asynchronous reset in the middle of CALC drops everything immediately.
      applyStimulus(8'd3, 8'd2);
      repeat (7) @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      checkOutput("midreset_BUSY", {31'h0, BUSY}, 0);
      checkOutput("midreset_DONE", {31'h0, DONE}, 0);
      checkOutput("midreset_Q", {16'h0, Q}, 0);
      checkOutput("midreset_R", {24'h0, R}, 0);
      checkOutput("midreset_DIV0", {31'h0, DIV0}, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      doneCount = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (DONE === 1'b1) doneCount++;
      end
      checkOutput("midreset_no_done", doneCount, 0);
      checkOutput("midreset_idle_BUSY", {31'h0, BUSY}, 0);
      doOp("post_reset_a4_b2", 8'd4, 8'd2, 17, 16'h0200, 8'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
